// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, drives the combinational
// instruction-memory address, and registers the returned word into IF/ID.
// Redirects (branch_taken) override freeze; reset (rst, active-low,
// synchronous) overrides everything.
// Optional feature macro: FETCH_PERF_CNT_EN builds the fetch/flush counters;
// when undefined both counter outputs are tied to zero.
module fetch_stage #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    parameter int                  PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_addr,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic [WORD_LEN-1:0] imem_instruction,
    output logic [WORD_LEN-1:0] if_pc,
    output logic [WORD_LEN-1:0] if_instr,
    output logic                if_valid,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         flush_cnt
);

    localparam logic [WORD_LEN-1:0] STEP = WORD_LEN'(PC_STEP);

    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] if_pc_q, if_pc_d;
    logic [WORD_LEN-1:0] if_instr_q, if_instr_d;
    logic                if_valid_q, if_valid_d;
    logic                do_fetch;
    logic                do_flush;

    // PC + step is shared by the next PC and the IF/ID pc field; wraps modulo 2^WORD_LEN.
    logic [WORD_LEN-1:0] pc_inc;
    assign pc_inc = pc_q + STEP;

    // Next-state selection: redirect beats freeze, freeze beats advance.
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        do_fetch   = 1'b0;
        do_flush   = 1'b0;
        if (branch_taken) begin
            pc_d       = branch_addr;
            if_pc_d    = '0;
            if_instr_d = '0;
            if_valid_d = 1'b0;
            do_flush   = 1'b1;
        end else if (!freeze) begin
            pc_d       = pc_inc;
            if_pc_d    = pc_inc;
            if_instr_d = imem_instruction;
            if_valid_d = 1'b1;
            do_fetch   = 1'b1;
        end
    end

    // PC and IF/ID register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counters advance only on accepted fetches / performed redirects.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + (do_fetch ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (do_flush ? 32'd1 : 32'd0);
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counters not built: strobes are intentionally left unused.
    logic unused_strobes;
    assign unused_strobes = do_fetch ^ do_flush;
    assign fetch_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A reference model computes the expected
// state for each edge and pushes it to a scoreboard queue; after the edge
// the entry is popped and compared against the DUT outputs.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    always #5 clk = ~clk;

    // Memory contents: distinct from the address and never zero for small addresses.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_instruction = mem_word(imem_addr);

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .if_valid         (if_valid),
        .fetch_cnt        (fetch_cnt),
        .flush_cnt        (flush_cnt)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] fcnt;
        logic [31:0] rcnt;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [31:0] m_pc, m_ifpc, m_instr, m_fcnt, m_rcnt;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, predict the edge outcome, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic fz,
                        input logic bt, input logic [31:0] ba);
        exp_t e;
        rst = r; freeze = fz; branch_taken = bt; branch_addr = ba;
        if (!r) begin
            m_pc = 32'h0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_fcnt = 0; m_rcnt = 0;
        end else if (bt) begin
            m_pc = ba; m_ifpc = 0; m_instr = 0; m_valid = 0; m_rcnt = m_rcnt + 1;
        end else if (!fz) begin
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_fcnt  = m_fcnt + 1;
        end
        e.tag = tag; e.pc = m_pc; e.ifpc = m_ifpc; e.instr = m_instr; e.valid = m_valid;
`ifdef FETCH_PERF_CNT_EN
        e.fcnt = m_fcnt; e.rcnt = m_rcnt;
`else
        e.fcnt = 32'h0;  e.rcnt = 32'h0;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, ".imem_addr"}, imem_addr, e.pc);
            chk({e.tag, ".if_pc"},     if_pc,     e.ifpc);
            chk({e.tag, ".if_instr"},  if_instr,  e.instr);
            chk({e.tag, ".if_valid"},  {31'h0, if_valid}, {31'h0, e.valid});
            chk({e.tag, ".fetch_cnt"}, fetch_cnt, e.fcnt);
            chk({e.tag, ".flush_cnt"}, flush_cnt, e.rcnt);
            $display("step %-12s addr=%08h if_pc=%08h instr=%08h v=%0d fc=%0d rc=%0d",
                     e.tag, imem_addr, if_pc, if_instr, if_valid, fetch_cnt, flush_cnt);
        end
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_fcnt = 0; m_rcnt = 0;
        #1;
        // Reset held two cycles, then sequential fetch 0,4,8.
        step("rst0",     1'b0, 1'b0, 1'b0, 32'h0);
        step("rst1",     1'b0, 1'b1, 1'b1, 32'h40);
        step("seq0",     1'b1, 1'b0, 1'b0, 32'h0);
        step("seq1",     1'b1, 1'b0, 1'b0, 32'h0);
        // Freeze three cycles at PC = 8 (branch_addr noise must be ignored).
        step("frz0",     1'b1, 1'b1, 1'b0, 32'hDEAD_BEEC);
        step("frz1",     1'b1, 1'b1, 1'b0, 32'h0);
        step("frz2",     1'b1, 1'b1, 1'b0, 32'h0);
        step("seq2",     1'b1, 1'b0, 1'b0, 32'h0);
        step("seq3",     1'b1, 1'b0, 1'b0, 32'h0);
        step("seq4",     1'b1, 1'b0, 1'b0, 32'h0);
        // Taken branch at PC = 20 to 44.
        step("br44",     1'b1, 1'b0, 1'b1, 32'd44);
        step("tgt44",    1'b1, 1'b0, 1'b0, 32'h0);
        step("seq5",     1'b1, 1'b0, 1'b0, 32'h0);
        // Simultaneous freeze and branch to 100.
        step("frzbr100", 1'b1, 1'b1, 1'b1, 32'd100);
        step("tgt100",   1'b1, 1'b0, 1'b0, 32'h0);
        // Wrap-around through FFFF_FFFC.
        step("brwrap",   1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("wrap0",    1'b1, 1'b0, 1'b0, 32'h0);
        step("wrap1",    1'b1, 1'b0, 1'b0, 32'h0);
        // Misaligned target used as given.
        step("brmis",    1'b1, 1'b0, 1'b1, 32'h0000_0102);
        step("mis0",     1'b1, 1'b0, 1'b0, 32'h0);
        step("frzlast",  1'b1, 1'b1, 1'b0, 32'h0);
        // Reset while freeze and branch are both asserted.
        step("rstfb",    1'b0, 1'b1, 1'b1, 32'h0000_0200);
        step("post0",    1'b1, 1'b0, 1'b0, 32'h0);
        step("post1",    1'b1, 1'b0, 1'b0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. Owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register for the decode stage. Handles pipeline freeze from hazard detection and PC redirection and flush from taken branches and jumps resolved downstream.

## Interface

Parameters:
- `WORD_LEN`, 32, width of PC, address and instruction.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `PC_STEP`, 4, byte increment per sequential fetch.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset. `rst`=0 at a rising edge resets all state.
- `freeze` input 1: hazard stall from decode; holds PC and IF/ID.
- `branch_taken` input 1: redirect request from the branch resolution stage.
- `branch_addr` input `WORD_LEN`: byte address to redirect to when `branch_taken`=1.
- `imem_addr` output `WORD_LEN`: combinational copy of the current PC, wired to the instruction memory `addr`.
- `imem_instruction` input `WORD_LEN`: combinational instruction word returned by the memory.
- `if_pc` output `WORD_LEN`: registered PC+`PC_STEP` of the instruction held in IF/ID.
- `if_instr` output `WORD_LEN`: registered instruction word.
- `if_valid` output 1: registered; 1 = IF/ID holds a real fetched instruction.
- `fetch_cnt` output 32: count of instructions accepted into IF/ID.
- `flush_cnt` output 32: count of redirects performed.

## Operation

- State: `pc`, IF/ID register (`if_pc`, `if_instr`, `if_valid`), and counters.
- The cycle action is chosen by this priority, evaluated each rising edge:
  1. **RESET** (`rst`=0): `pc`←`RESET_PC`, `if_pc`←0, `if_instr`←0 (NOP encoding), `if_valid`←0, counters←0.
  2. **REDIRECT** (`branch_taken`=1, overrides `freeze`): `pc`←`branch_addr`. IF/ID is flushed: `if_instr`←0, `if_valid`←0, `if_pc`←0. `flush_cnt`+1.
  3. **HOLD** (`freeze`=1): `pc`, IF/ID and counters are unchanged.
  4. **ADVANCE**: `pc`←`pc`+`PC_STEP`. `if_instr`←`imem_instruction`, `if_pc`←`pc`+`PC_STEP`, `if_valid`←1. `fetch_cnt`+1.
- PC arithmetic is modulo 2^`WORD_LEN`. 32'hFFFF_FFFC + 4 wraps to 0 with no flag. Memory-side address truncation belongs to the memory.
- `branch_addr` is used as given. Misaligned values (low 2 bits ≠ 0) are not corrected.
- Counters wrap modulo 2^32.
- The stage does not latch pending redirects. `branch_taken` must be held by its source only for the one cycle it is meant to act.

## Timing

- `imem_addr` = `pc`, with zero-cycle combinational path. The instruction is sampled in the same cycle it is addressed.
- Fetch-to-decode latency: 1 cycle. The word addressed in cycle N appears on `if_instr` after edge N+1.
- Redirect penalty: the edge on which `branch_taken`=1 loads the target and emits one bubble. The target instruction appears on `if_instr` one edge later.
- Freeze: for every cycle `freeze`=1 and `branch_taken`=0, outputs are bit-identical to the previous cycle.
- Reset mid-stream: takes effect on the first edge with `rst`=0 regardless of other inputs. The first fetch after reset release addresses `RESET_PC`.

## Configuration

- `FETCH_PERF_CNT_EN`:
  - Defined: `fetch_cnt` and `flush_cnt` are implemented as described above.
  - Undefined: no counter registers are built, and both ports are tied to constant 0.
  - All other behaviour is identical in both cases.

## Test plan

- **Reset and sequential fetch:** hold `rst`=0 for 2 cycles, release, memory returns word = address. Required: `imem_addr` = 0, 4, 8, 12 on successive cycles; `if_instr` lags by one cycle; `if_pc` = 4, 8, 12; `if_valid` rises 1 edge after release.
- **Freeze:** freeze for 3 cycles at PC = 8. Required: `imem_addr` stays 8; `if_instr`/`if_pc`/`if_valid` unchanged for 3 cycles; on release the fetch resumes at 8 then 12; `fetch_cnt` does not count frozen cycles.
- **Taken branch:** at PC = 20, pulse `branch_taken` with `branch_addr` = 44. Required: next cycle `imem_addr` = 44, `if_valid` = 0, `if_instr` = 0; the following cycle `if_instr` = word@44, `if_pc` = 48; `flush_cnt` = 1.
- **Simultaneous freeze and branch:** `freeze`=1 and `branch_taken`=1 with `branch_addr` = 100. Required: PC ← 100 and IF/ID flushed; freeze is ignored for that edge.
- **Wrap-around:** redirect to 32'hFFFF_FFFC, then advance. Required: `imem_addr` = 0 next; `if_pc` = 0 for the word fetched at FFFF_FFFC.
- **Reset during freeze and branch:** assert `rst`=0 while `freeze`=1 and `branch_taken`=1. Required: `pc` = `RESET_PC`, `if_valid` = 0, counters = 0 after that edge. With `FETCH_PERF_CNT_EN` undefined, both counters read 0 throughout all scenarios.
